// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1/8N2 UART transmitter on FPGA_SYSCLK.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2 frames).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                         FPGA_SYSCLK,
  input  logic                         RESET,
  input  logic [7:0]                   s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic                         UART_RXD_OUT,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            rdy_q, rdy_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            baud_end;
  logic [7:0]      head_byte;

  // rdy_q keeps s_tready low during reset and for the release edge itself.
  assign fifo_level   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty   = (fifo_level == '0);
  assign s_tready     = rdy_q && (fifo_level != FULL_LEVEL);
  assign push         = s_tvalid && s_tready;
  assign head_byte    = mem_q[rd_ptr_q[AW-1:0]];
  assign baud_end     = (baud_q == BAUD_LAST);
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign UART_RXD_OUT = tx_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    rdy_d    = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = head_byte;
          state_d = ST_START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          state_d = ST_STOP;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        // Next byte is taken on the closing stop edge so frames abut.
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              data_d  = head_byte;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^data_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge FPGA_SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge FPGA_SYSCLK) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_tdata;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued and a line
// monitor decodes every frame bit-by-bit against a reference frame.
module tb_uart_tx_fifo;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int STOP  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS  = 1 + 8 + PAR_BITS + STOP;
  localparam int FRAME  = NBITS * C;
  localparam int BUDGET = 4000;

  logic                     FPGA_SYSCLK = 1'b0;
  logic                     RESET;
  logic [7:0]               s_tdata;
  logic                     s_tvalid;
  logic                     s_tready;
  logic                     UART_RXD_OUT;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_level;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cycle        = 0;
  int          last_accept  = 0;
  int          peak_level   = 0;
  bit          mon_in_frame = 1'b0;
  logic [7:0]  exp_q[$];
  int          start_times[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH),
    .STOP_BITS    (STOP)
  ) dut (
    .FPGA_SYSCLK  (FPGA_SYSCLK),
    .RESET        (RESET),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .UART_RXD_OUT (UART_RXD_OUT),
    .busy         (busy),
    .fifo_level   (fifo_level)
  );

  always #5 FPGA_SYSCLK = ~FPGA_SYSCLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every handshake pushes the byte the line must later carry.
  initial forever begin
    @(posedge FPGA_SYSCLK);
    cycle++;
    if (!RESET && s_tvalid && s_tready) begin
      exp_q.push_back(s_tdata);
      last_accept = cycle;
    end
  end

  initial begin : monitor
    logic [7:0] b;
    logic       bits [NBITS];
    bit         aborted;
    bit         bad;
    forever begin
      @(negedge FPGA_SYSCLK);
      if (RESET || UART_RXD_OUT) continue;
      start_times.push_back(cycle);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame", 32'd1, 32'd0);
        repeat (FRAME) @(negedge FPGA_SYSCLK);
        continue;
      end
      mon_in_frame = 1'b1;
      b = exp_q.pop_front();
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = b[i];
      if (PAR_BITS == 1) bits[9] = ^b;
      for (int i = 9 + PAR_BITS; i < NBITS; i++) bits[i] = 1'b1;
      aborted = 1'b0;
      for (int k = 0; k < NBITS && !aborted; k++) begin
        bad = 1'b0;
        for (int c = 0; c < C; c++) begin
          if (k != 0 || c != 0) @(negedge FPGA_SYSCLK);
          if (RESET) begin
            aborted = 1'b1;
            break;
          end
          if (UART_RXD_OUT !== bits[k]) bad = 1'b1;
        end
        if (!aborted)
          checkOutput($sformatf("frame_bit byte=%02h bit=%0d", b, k),
                      {31'd0, bad ? ~bits[k] : bits[k]}, {31'd0, bits[k]});
      end
      mon_in_frame = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] data);
    bit ok = 1'b0;
    s_tdata  = data;
    s_tvalid = 1'b1;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge FPGA_SYSCLK);
      ok = s_tready;
      @(posedge FPGA_SYSCLK);
      #1;
      if (ok) break;
    end
    s_tvalid = 1'b0;
    if (!ok) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    bit done = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge FPGA_SYSCLK);
      if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
      if (exp_q.size() == 0 && !mon_in_frame && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge FPGA_SYSCLK);
    @(posedge FPGA_SYSCLK);
    #1;
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge FPGA_SYSCLK);
    tests_failed++;
    $display("[TB] FAIL watchdog: got cycle limit, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int  accepted;
    int  lows;
    bit  ok;
    logic [7:0] d;

    RESET    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 8'h3C;
    repeat (20) begin
      @(negedge FPGA_SYSCLK);
      checkOutput("reset_line", {31'd0, UART_RXD_OUT}, 32'd1);
      checkOutput("reset_tready", {31'd0, s_tready}, 32'd0);
      checkOutput("reset_level", {29'd0, fifo_level}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge FPGA_SYSCLK);
    #1;
    RESET    = 1'b0;
    s_tvalid = 1'b0;
    checkOutput("tready_before_edge", {31'd0, s_tready}, 32'd0);
    @(posedge FPGA_SYSCLK);
    #1;
    checkOutput("tready_after_release", {31'd0, s_tready}, 32'd1);

    // Single byte: latency, occupancy and busy window.
    start_times.delete();
    applyStimulus(8'hA5);
    for (int n = 0; n <= FRAME + 1; n++) begin
      @(negedge FPGA_SYSCLK);
      if (n == 0) checkOutput("single_level_k", {29'd0, fifo_level}, 32'd1);
      if (n == 1) checkOutput("single_level_pop", {29'd0, fifo_level}, 32'd0);
      if (n == FRAME) checkOutput("single_busy_end", {31'd0, busy}, 32'd1);
      if (n == FRAME + 1) checkOutput("single_busy_drop", {31'd0, busy}, 32'd0);
    end
    waitIdle();
    checkOutput("single_frames", start_times.size(), 32'd1);
    if (start_times.size() >= 1)
      checkOutput("single_latency", start_times[0] - last_accept, 32'd2);

    // Back-to-back frames must abut exactly.
    start_times.delete();
    peak_level = 0;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h55);
    waitIdle();
    checkOutput("b2b_frames", start_times.size(), 32'd3);
    checkOutput("b2b_peak_level", peak_level, 32'd2);
    if (start_times.size() == 3) begin
      checkOutput("b2b_gap1", start_times[1] - start_times[0], FRAME);
      checkOutput("b2b_gap2", start_times[2] - start_times[1], FRAME);
    end

    applyStimulus(8'h07);
    waitIdle();
    applyStimulus(8'h03);
    waitIdle();

    // Saturate the FIFO and keep pushing across a pointer wrap.
    s_tdata  = 8'h10;
    s_tvalid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge FPGA_SYSCLK);
      ok = s_tready;
      checkOutput("tready_vs_full", {31'd0, s_tready}, {31'd0, (int'(fifo_level) != DEPTH)});
      @(posedge FPGA_SYSCLK);
      #1;
      if (ok) begin
        accepted++;
        s_tdata = s_tdata + 8'd1;
      end
      if (i == 7) begin
        checkOutput("full_accept_count", accepted, 32'd5);
        checkOutput("full_level", {29'd0, fifo_level}, DEPTH);
      end
    end
    s_tvalid = 1'b0;
    waitIdle();

    for (int r = 0; r < 30; r++) begin
      int gap;
      gap = int'($urandom_range(0, 60));
      d = 8'($urandom);
      applyStimulus(d);
      if (gap > 0) begin
        repeat (gap) @(posedge FPGA_SYSCLK);
        #1;
      end
    end
    waitIdle();

    // Reset mid-frame during data bit 3 with two bytes still queued.
    applyStimulus(8'h21);
    applyStimulus(8'h9C);
    applyStimulus(8'h4E);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge FPGA_SYSCLK);
      if (!UART_RXD_OUT) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("reset_start_timeout", 32'd0, 32'd1);
    repeat (4 * C + 1) @(negedge FPGA_SYSCLK);
    checkOutput("midframe_level", {29'd0, fifo_level}, 32'd2);
    checkOutput("midframe_line", {31'd0, UART_RXD_OUT}, 32'd0);
    #1;
    RESET = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("async_line", {31'd0, UART_RXD_OUT}, 32'd1);
    checkOutput("async_level", {29'd0, fifo_level}, 32'd0);
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_tready", {31'd0, s_tready}, 32'd0);
    repeat (3) @(posedge FPGA_SYSCLK);
    #1;
    RESET = 1'b0;
    lows = 0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge FPGA_SYSCLK);
      if (!UART_RXD_OUT) lows++;
    end
    checkOutput("post_reset_low_cycles", lows, 32'd0);
    checkOutput("post_reset_level", {29'd0, fifo_level}, 32'd0);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
